// File: rtl/apb_timer_master.sv
// APB requester for the timer register slave.
// Runs one command per SETUP/ACCESS transfer with a wait-state timeout.
module apb_timer_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_inc;
  logic          expire;

  // Saturating next wait count and abort condition for this ACCESS cycle.
  always_comb begin
    cnt_inc = wait_cnt;
    if (wait_cnt != '1) begin
      cnt_inc = wait_cnt + CW'(1);
    end
    expire = (TIMEOUT != 0) && (32'(cnt_inc) >= 32'(TIMEOUT));
  end

  // Transfer sequencer; every output is a register.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            wait_cnt  <= '0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (PREADY) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
          end else if (expire) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule
